sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised successor to the team's dual-clock `fifo`, for producer/consumer pairs sharing one clock domain. It keeps the same valid/full write side and valid/ack first-word-fall-through read side, and adds:
- arbitrary (non-power-of-2) depth;
- fill count;
- programmable almost-full and almost-empty flags;
- synchronous flush;
- sticky overflow and underflow error flags.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: width of `data_in` and `data_out`.
- `BUFFER_SIZE`, default 127: number of entries; legal range 2..1024, any integer.
- `ALMOST_FULL_LEVEL`, default 123: `data_in_almost_full` is asserted when `fill_count` >= this value; legal range 1..`BUFFER_SIZE`.
- `ALMOST_EMPTY_LEVEL`, default 4: `data_out_almost_empty` is asserted when `fill_count` <= this value; legal range 0..`BUFFER_SIZE`-1.
- Derived localparam `CW` = $clog2(`BUFFER_SIZE`+1).

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous clear of contents and error flags.
- `data_in`  in  `DATA_WIDTH`  write data.
- `data_in_valid`  in  1  write request.
- `data_in_full`  out  1  FIFO holds `BUFFER_SIZE` entries.
- `data_in_almost_full`  out  1  fill level >= `ALMOST_FULL_LEVEL`.
- `data_out`  out  `DATA_WIDTH`  head entry; forced to 0 when `data_out_valid`=0.
- `data_out_valid`  out  1  FIFO non-empty; head entry presented.
- `data_out_ack`  in  1  consumer pops the head entry.
- `data_out_almost_empty`  out  1  fill level <= `ALMOST_EMPTY_LEVEL`.
- `fill_count`  out  `CW`  current number of stored entries.
- `overflow`  out  1  sticky: a write was attempted while full.
- `underflow`  out  1  sticky: a pop was attempted while empty.

## Operation
- Storage:
  - `BUFFER_SIZE`-entry register array, write pointer `wp` and read pointer `rp`, each 0..`BUFFER_SIZE`-1.
  - Each pointer wraps from `BUFFER_SIZE`-1 to 0 by explicit compare, not by bit truncation.
- Event definitions:
  - Push = `data_in_valid` & !`data_in_full`. On push, `data_in` is written at `wp` and `wp` advances.
  - Pop = `data_out_ack` & `data_out_valid`. On pop, `rp` advances.
- `fill_count` update:
  - Increments on push only.
  - Decrements on pop only.
  - Unchanged when push and pop occur together, or when neither occurs.
- `data_in_full` is taken from the registered count, so a pop in the same cycle does NOT free space for a write. Write while full = dropped; sets `overflow`.
- Write while empty is accepted. It cannot be popped in the same cycle, because `data_out_valid` was 0.
- `data_out_ack` while `data_out_valid`=0 = no effect on pointers; sets `underflow`.
- Status outputs are decoded from registered `fill_count`:
  - `data_out_valid` = (count != 0)
  - `data_in_full` = (count == `BUFFER_SIZE`)
  - `data_in_almost_full` = (count >= `ALMOST_FULL_LEVEL`)
  - `data_out_almost_empty` = (count <= `ALMOST_EMPTY_LEVEL`)
- `data_out` = mem[`rp`] gated by `data_out_valid`. It is a first-word-fall-through read: no ack is needed to see the head.
- Priority, highest first:
  1. `rst`
  2. `flush`
  3. push/pop
- Flush behaviour:
  - Sets `wp`=`rp`=0, count=0, and clears `overflow`/`underflow`.
  - A concurrent push or ack is ignored and does not set any error flag.
  - The memory array is not cleared.
- Reset: identical to flush. Reset values:
  - `data_in_full`=0, `data_in_almost_full`=0.
  - `data_out_valid`=0, `data_out`=0.
  - `data_out_almost_empty`=1, `fill_count`=0.
  - `overflow`=0, `underflow`=0.
  - `rst` asserted mid-operation discards all stored data on that edge.
- Error flags stay set until `rst` or `flush`.

## Timing
- Write-to-read latency is 1 cycle: a word pushed at edge N appears on `data_out` with `data_out_valid`=1 after edge N.
- A pop at edge N presents the next entry (or `data_out_valid`=0) after edge N.
- All flags update after the edge that changes the count. They depend only on registers; there is no combinational path from inputs to any status output.
- `data_out` depends combinationally on registered `rp` and the array only. There is no input-to-output path.
- Full throughput: one push and one pop per cycle, sustained, whenever 0 < count < `BUFFER_SIZE`.
- `flush`/`rst` take effect at the edge where they are sampled high. Outputs show reset values from the following cycle.

## Test plan
- Reset, then push 0x00000001, 0x00000002, 0x00000004 on consecutive cycles with ack=0:
  - `fill_count` 1,2,3.
  - `data_out`=0x00000001 one cycle after the first push.
  - 3 acks return 1, 2, 4 in order, then `data_out_valid`=0 and `data_out`=0.
- `BUFFER_SIZE`=5, push 5 words:
  - `data_in_full`=1.
  - A 6th push with simultaneous ack: the write is dropped, `overflow`=1, `fill_count`=4, and the popped word is the first one written.
- `BUFFER_SIZE`=5, run 23 cycles of simultaneous push/pop at count 2:
  - count stays 2.
  - Data out is in order across multiple pointer wraps at 4→0.
- Defaults, fill to 123: `data_in_almost_full` rises on the edge where the count reaches 123. Drain to 4: `data_out_almost_empty` rises at count 4.
- Empty FIFO, assert ack: `underflow`=1, count stays 0.
- `flush` with count 10 plus a concurrent push: count=0, `underflow`/`overflow`=0, `data_out_valid`=0 on the next cycle.
- `rst` with count 7: all outputs show reset values next cycle. A subsequent push of 0xDEADBEEF is read back first.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with arbitrary depth, fill count,
// programmable almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sync_fifo #(
    parameter int DATA_WIDTH         = 32,
    parameter int BUFFER_SIZE        = 127,
    parameter int ALMOST_FULL_LEVEL  = 123,
    parameter int ALMOST_EMPTY_LEVEL = 4,
    localparam int CW                = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_full,
    output logic                  data_in_almost_full,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ack,
    output logic                  data_out_almost_empty,
    output logic [CW-1:0]         fill_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = $clog2(BUFFER_SIZE);
    localparam logic [PW-1:0] LAST_PTR = PW'(BUFFER_SIZE - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(BUFFER_SIZE);
    localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(ALMOST_EMPTY_LEVEL);

    typedef struct packed {
        logic valid;
        logic full;
        logic almost_full;
        logic almost_empty;
    } status_t;

    // Depth need not be a power of two, so wrap by compare rather than truncation.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == LAST_PTR) begin
            r = {PW{1'b0}};
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    function automatic status_t decode(input logic [CW-1:0] c);
        status_t s;
        s.valid        = (c != {CW{1'b0}});
        s.full         = (c == FULL_CNT);
        s.almost_full  = (c >= AF_CNT);
        s.almost_empty = (c <= AE_CNT);
        return s;
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [BUFFER_SIZE];
    logic [PW-1:0]         wp_r;
    logic [PW-1:0]         rp_r;
    logic [CW-1:0]         count_r;
    status_t               status_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic                  push_s;
    logic                  pop_s;
    logic                  mem_we_s;
    logic [PW-1:0]         wp_nxt_s;
    logic [PW-1:0]         rp_nxt_s;
    logic [CW-1:0]         count_nxt_s;
    status_t               status_nxt_s;
    logic                  overflow_nxt_s;
    logic                  underflow_nxt_s;

    // Next-state decode: flush dominates and suppresses both transfers and error capture.
    always_comb begin
        push_s          = data_in_valid & ~status_r.full;
        pop_s           = data_out_ack & status_r.valid;
        mem_we_s        = 1'b0;
        wp_nxt_s        = wp_r;
        rp_nxt_s        = rp_r;
        count_nxt_s     = count_r;
        overflow_nxt_s  = overflow_r;
        underflow_nxt_s = underflow_r;
        if (flush) begin
            wp_nxt_s        = {PW{1'b0}};
            rp_nxt_s        = {PW{1'b0}};
            count_nxt_s     = {CW{1'b0}};
            overflow_nxt_s  = 1'b0;
            underflow_nxt_s = 1'b0;
        end else begin
            mem_we_s        = push_s & ~rst;
            overflow_nxt_s  = overflow_r | (data_in_valid & status_r.full);
            underflow_nxt_s = underflow_r | (data_out_ack & ~status_r.valid);
            if (push_s) begin
                wp_nxt_s = ptr_inc(wp_r);
            end else begin
                wp_nxt_s = wp_r;
            end
            if (pop_s) begin
                rp_nxt_s = ptr_inc(rp_r);
            end else begin
                rp_nxt_s = rp_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CW'(1);
                2'b01:   count_nxt_s = count_r - CW'(1);
                default: count_nxt_s = count_r;
            endcase
        end
        status_nxt_s = decode(count_nxt_s);
    end

    // Control state; flags are registered alongside the count they are decoded from.
    always_ff @(posedge clock) begin
        if (rst) begin
            wp_r        <= {PW{1'b0}};
            rp_r        <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            status_r    <= decode({CW{1'b0}});
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wp_r        <= wp_nxt_s;
            rp_r        <= rp_nxt_s;
            count_r     <= count_nxt_s;
            status_r    <= status_nxt_s;
            overflow_r  <= overflow_nxt_s;
            underflow_r <= underflow_nxt_s;
        end
    end

    // Storage array; contents survive reset and flush and are hidden by the valid gate.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_r[wp_r] <= data_in;
        end
    end

    assign data_out              = status_r.valid ? mem_r[rp_r] : {DATA_WIDTH{1'b0}};
    assign data_out_valid        = status_r.valid;
    assign data_in_full          = status_r.full;
    assign data_in_almost_full   = status_r.almost_full;
    assign data_out_almost_empty = status_r.almost_empty;
    assign fill_count            = count_r;
    assign overflow              = overflow_r;
    assign underflow             = underflow_r;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a vector table on a 5-deep instance plus hand-written
// sequences (streaming wrap, thresholds, reset, flush) on a default-sized instance.
module tb_sync_fifo;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Small instance: depth 5, almost-full at 4, almost-empty at 1.
    logic        b_rst, b_flush, b_vld, b_ack;
    logic [31:0] b_din;
    logic        b_full, b_af, b_ovalid, b_ae, b_ovf, b_unf;
    logic [31:0] b_dout;
    logic [2:0]  b_cnt;

    sync_fifo #(.DATA_WIDTH(32), .BUFFER_SIZE(5), .ALMOST_FULL_LEVEL(4), .ALMOST_EMPTY_LEVEL(1)) dut_b (
        .clock(clock), .rst(b_rst), .flush(b_flush),
        .data_in(b_din), .data_in_valid(b_vld), .data_in_full(b_full),
        .data_in_almost_full(b_af), .data_out(b_dout), .data_out_valid(b_ovalid),
        .data_out_ack(b_ack), .data_out_almost_empty(b_ae), .fill_count(b_cnt),
        .overflow(b_ovf), .underflow(b_unf)
    );

    // Default instance: depth 127, almost-full at 123, almost-empty at 4.
    logic        a_rst, a_flush, a_vld, a_ack;
    logic [31:0] a_din;
    logic        a_full, a_af, a_ovalid, a_ae, a_ovf, a_unf;
    logic [31:0] a_dout;
    logic [6:0]  a_cnt;

    sync_fifo dut_a (
        .clock(clock), .rst(a_rst), .flush(a_flush),
        .data_in(a_din), .data_in_valid(a_vld), .data_in_full(a_full),
        .data_in_almost_full(a_af), .data_out(a_dout), .data_out_valid(a_ovalid),
        .data_out_ack(a_ack), .data_out_almost_empty(a_ae), .fill_count(a_cnt),
        .overflow(a_ovf), .underflow(a_unf)
    );

    typedef struct {
        logic        rst, flush, wv;
        logic [31:0] wd;
        logic        ack;
        logic [2:0]  cnt;
        logic        vld;
        logic [31:0] dout;
        logic        full, af, ae, ovf, unf;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic a_idle();
        a_rst = 1'b0; a_flush = 1'b0; a_vld = 1'b0; a_ack = 1'b0; a_din = 32'h0;
    endtask

    task automatic a_reset_vals(input string tag);
        chk({tag, "_cnt"},   32'(a_cnt),    32'd0);
        chk({tag, "_vld"},   32'(a_ovalid), 32'd0);
        chk({tag, "_dout"},  a_dout,        32'h0);
        chk({tag, "_full"},  32'(a_full),   32'd0);
        chk({tag, "_af"},    32'(a_af),     32'd0);
        chk({tag, "_ae"},    32'(a_ae),     32'd1);
        chk({tag, "_ovf"},   32'(a_ovf),    32'd0);
        chk({tag, "_unf"},   32'(a_unf),    32'd0);
    endtask

    function automatic vec_t mk(input logic r, input logic f, input logic wv, input logic [31:0] wd,
                                input logic ack, input logic [2:0] cnt, input logic vld,
                                input logic [31:0] dout, input logic full, input logic af,
                                input logic ae, input logic ovf, input logic unf);
        vec_t v;
        v.rst = r; v.flush = f; v.wv = wv; v.wd = wd; v.ack = ack;
        v.cnt = cnt; v.vld = vld; v.dout = dout; v.full = full; v.af = af;
        v.ae = ae; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    initial begin
        //             rst   flush wv    wd       ack  | cnt  vld   dout     full  af    ae    ovf   unf
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 3'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b1, 32'h1,  1'b0, 3'd1, 1'b1, 32'h1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b1, 32'h2,  1'b0, 3'd2, 1'b1, 32'h1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b1, 32'h4,  1'b0, 3'd3, 1'b1, 32'h1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 3'd2, 1'b1, 32'h2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 3'd1, 1'b1, 32'h4,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 3'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 3'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[8]  = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 3'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 3'd1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 3'd2, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, 1'b0, 1'b1, 32'h12, 1'b0, 3'd3, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 1'b1, 32'h13, 1'b0, 3'd4, 1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 1'b0, 1'b1, 32'h14, 1'b0, 3'd5, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(1'b0, 1'b0, 1'b1, 32'h15, 1'b1, 3'd4, 1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 3'd3, 1'b1, 32'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[16] = mk(1'b0, 1'b0, 1'b1, 32'h16, 1'b1, 3'd3, 1'b1, 32'h13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[17] = mk(1'b0, 1'b1, 1'b1, 32'h99, 1'b1, 3'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[18] = mk(1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 3'd1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[19] = mk(1'b1, 1'b0, 1'b1, 32'h30, 1'b1, 3'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        a_idle();
        a_rst = 1'b1;
        b_rst = 1'b1; b_flush = 1'b0; b_vld = 1'b0; b_ack = 1'b0; b_din = 32'h0;

        // Table on the small instance.
        for (int i = 0; i < NVEC; i++) begin
            b_rst = vecs[i].rst; b_flush = vecs[i].flush; b_vld = vecs[i].wv;
            b_din = vecs[i].wd;  b_ack = vecs[i].ack;
            step();
            chk($sformatf("vec%0d_cnt", i),  32'(b_cnt),    32'(vecs[i].cnt));
            chk($sformatf("vec%0d_vld", i),  32'(b_ovalid), 32'(vecs[i].vld));
            chk($sformatf("vec%0d_dout", i), b_dout,        vecs[i].dout);
            chk($sformatf("vec%0d_full", i), 32'(b_full),   32'(vecs[i].full));
            chk($sformatf("vec%0d_af", i),   32'(b_af),     32'(vecs[i].af));
            chk($sformatf("vec%0d_ae", i),   32'(b_ae),     32'(vecs[i].ae));
            chk($sformatf("vec%0d_ovf", i),  32'(b_ovf),    32'(vecs[i].ovf));
            chk($sformatf("vec%0d_unf", i),  32'(b_unf),    32'(vecs[i].unf));
            if (i == 0) a_rst = 1'b0;
        end

        // Streaming at count 2 on the small instance: pointers wrap several times.
        b_rst = 1'b0; b_flush = 1'b0; b_ack = 1'b0; b_vld = 1'b1;
        b_din = 32'h100; step();
        b_din = 32'h101; step();
        chk("stream_pre_cnt", 32'(b_cnt), 32'd2);
        b_ack = 1'b1;
        for (int i = 0; i < 23; i++) begin
            b_din = 32'h100 + 32'(i + 2);
            step();
            chk($sformatf("stream%0d_cnt", i),  32'(b_cnt), 32'd2);
            chk($sformatf("stream%0d_dout", i), b_dout,     32'h100 + 32'(i + 1));
        end
        b_vld = 1'b0; b_ack = 1'b0;

        // Default instance: reset state, then fill to the almost-full threshold.
        a_reset_vals("a_init");
        for (int i = 0; i < 123; i++) begin
            a_vld = 1'b1; a_din = 32'hA000_0000 + 32'(i);
            step();
            chk($sformatf("fill%0d_cnt", i), 32'(a_cnt), 32'(i + 1));
            chk($sformatf("fill%0d_af", i),  32'(a_af),  (i + 1 >= 123) ? 32'd1 : 32'd0);
        end
        chk("fill_head", a_dout, 32'hA000_0000);
        a_vld = 1'b0;

        // Drain down to the almost-empty threshold, checking order.
        for (int i = 0; i < 119; i++) begin
            a_ack = 1'b1;
            step();
            chk($sformatf("drain%0d_cnt", i),  32'(a_cnt), 32'(122 - i));
            chk($sformatf("drain%0d_dout", i), a_dout,     32'hA000_0000 + 32'(i + 1));
            chk($sformatf("drain%0d_ae", i),   32'(a_ae),  (122 - i <= 4) ? 32'd1 : 32'd0);
        end
        a_ack = 1'b0;

        // Grow to 7 then reset mid-operation.
        for (int i = 0; i < 3; i++) begin
            a_vld = 1'b1; a_din = 32'hB000_0000 + 32'(i);
            step();
        end
        a_vld = 1'b0;
        chk("pre_rst_cnt", 32'(a_cnt), 32'd7);
        a_rst = 1'b1; a_vld = 1'b1; a_din = 32'h5555_5555;
        step();
        a_idle();
        a_reset_vals("a_rst7");
        a_vld = 1'b1; a_din = 32'hDEAD_BEEF;
        step();
        a_vld = 1'b0;
        chk("beef_cnt",  32'(a_cnt),    32'd1);
        chk("beef_vld",  32'(a_ovalid), 32'd1);
        chk("beef_dout", a_dout,        32'hDEAD_BEEF);

        // Pop the word, provoke underflow, refill to 10, then flush with a concurrent push.
        a_ack = 1'b1; step();
        chk("pop_beef_cnt", 32'(a_cnt), 32'd0);
        step();
        a_ack = 1'b0;
        chk("unf_set",  32'(a_unf), 32'd1);
        chk("unf_cnt",  32'(a_cnt), 32'd0);
        for (int i = 0; i < 10; i++) begin
            a_vld = 1'b1; a_din = 32'hC000_0000 + 32'(i);
            step();
        end
        chk("pre_flush_cnt", 32'(a_cnt), 32'd10);
        chk("pre_flush_unf", 32'(a_unf), 32'd1);
        a_flush = 1'b1; a_vld = 1'b1; a_din = 32'h1234_5678;
        step();
        a_idle();
        chk("flush_cnt",  32'(a_cnt),    32'd0);
        chk("flush_vld",  32'(a_ovalid), 32'd0);
        chk("flush_dout", a_dout,        32'h0);
        chk("flush_unf",  32'(a_unf),    32'd0);
        chk("flush_ovf",  32'(a_ovf),    32'd0);
        chk("flush_ae",   32'(a_ae),     32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
